// File: rtl/bit16_misr_checker_pkg.sv
// Shared definitions for the BIST response analyser.
//   SIG_W        : signature width, equal to the {cout,sum[15:0]} response width
//   MISR_POLY    : Galois feedback mask for x^17 + x^14 + 1
//   misr_state_t : analyser FSM states
package bist_pkg;

  localparam int SIG_W = 17;
  localparam logic [SIG_W-1:0] MISR_POLY = 17'h04001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_t;

endpackage

// File: rtl/bit16_misr_checker_if.sv
// Control/data bundle between the BIST sequencer and the MISR checker.
//   start, data_valid, data_in, golden : sequencer -> checker
//   busy, done, pass, signature, pat_cnt : checker -> sequencer
// The checker uses the slave modport; the sequencer side uses master.
interface bit16_misr_checker_if;
  import bist_pkg::*;

  logic             start;
  logic             data_valid;
  logic [SIG_W-1:0] data_in;
  logic [SIG_W-1:0] golden;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [15:0]      pat_cnt;

  modport master (
    output start, data_valid, data_in, golden,
    input  busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, data_valid, data_in, golden,
    output busy, done, pass, signature, pat_cnt
  );

endinterface

// File: rtl/bit16_misr_checker_misr17_step.sv
// misr17_step: one combinational MISR update.
//   sig      in  : current signature
//   data_in  in  : response word to compact
//   sig_next out : signature after compacting data_in
// The MSB shifts out and is not wrapped around; when it is set the feedback
// mask is XORed into the shifted value instead.
module misr17_step
  import bist_pkg::*;
(
  input  logic [SIG_W-1:0] sig,
  input  logic [SIG_W-1:0] data_in,
  output logic [SIG_W-1:0] sig_next
);

  assign sig_next = {sig[SIG_W-2:0], 1'b0}
                  ^ (sig[SIG_W-1] ? MISR_POLY : '0)
                  ^ data_in;

endmodule

// File: rtl/bit16_misr_checker.sv
// bit16_misr_checker: compacts PATTERNS valid response words into a 17-bit
// MISR signature and compares the result against a golden value.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   seed : (only when MISR_SEED_EN is defined) signature loaded on each start;
//          without MISR_SEED_EN the seed is constant 0
//   bus  : bit16_misr_checker_if.slave (start/data/golden in, status out)
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | compacting valid words, stalls while data_valid=0
// DONE  | signature/count frozen, pass valid, start restarts directly
module bit16_misr_checker
  import bist_pkg::*;
#(
  parameter int PATTERNS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef MISR_SEED_EN
  input  logic [SIG_W-1:0]        seed,
`endif
  bit16_misr_checker_if.slave     bus
);

  localparam logic [15:0] LAST_CNT = 16'(PATTERNS - 1);

  misr_state_t      state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d, sig_next, seed_w;
  logic [15:0]      cnt_q, cnt_d;
  logic             pass_q, pass_d;

`ifdef MISR_SEED_EN
  assign seed_w = seed;
`else
  assign seed_w = '0;
`endif

  misr17_step u_step (
    .sig      (sig_q),
    .data_in  (bus.data_in),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        // start outranks data_valid here; the coincident word is dropped
        if (bus.start) begin
          sig_d   = seed_w;
          cnt_d   = '0;
          pass_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.data_valid) begin
          sig_d = sig_next;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_CNT) begin
            // compare the post-update signature so pass lines up with done
            pass_d  = (sig_next == bus.golden);
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.pat_cnt   = cnt_q;

endmodule

// File: tb/tb_bit16_misr_checker.sv
module tb_bit16_misr_checker;
  import bist_pkg::*;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] sig;
    logic [15:0]      cnt;
  } obs_t;

  typedef struct {
    logic [SIG_W-1:0] sig;
    logic [15:0]      cnt;
    logic             pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

`ifdef MISR_SEED_EN
  logic [SIG_W-1:0] seed_val;
`endif

  always #5 clk = ~clk;

  bit16_misr_checker_if if_a ();
  bit16_misr_checker_if if_b ();
  bit16_misr_checker_if if_c ();

  bit16_misr_checker #(.PATTERNS(1)) u_p1 (
    .clk (clk),
    .rst (rst),
`ifdef MISR_SEED_EN
    .seed(seed_val),
`endif
    .bus (if_a.slave)
  );

  bit16_misr_checker #(.PATTERNS(2)) u_p2 (
    .clk (clk),
    .rst (rst),
`ifdef MISR_SEED_EN
    .seed(seed_val),
`endif
    .bus (if_b.slave)
  );

  bit16_misr_checker #(.PATTERNS(256)) u_p256 (
    .clk (clk),
    .rst (rst),
`ifdef MISR_SEED_EN
    .seed(seed_val),
`endif
    .bus (if_c.slave)
  );

  // reference MISR step: shift left dropping the MSB, fold in the mask when MSB was set
  function automatic logic [SIG_W-1:0] m_step(logic [SIG_W-1:0] s, logic [SIG_W-1:0] d);
    logic [SIG_W-1:0] r;
    r = s << 1;
    if (s[SIG_W-1]) r = r ^ 17'h04001;
    return r ^ d;
  endfunction

  function automatic logic [SIG_W-1:0] seed_exp();
`ifdef MISR_SEED_EN
    return seed_val;
`else
    return '0;
`endif
  endfunction

  function automatic obs_t get_obs(int k);
    obs_t o;
    case (k)
      0:       o = '{if_a.busy, if_a.done, if_a.pass, if_a.signature, if_a.pat_cnt};
      1:       o = '{if_b.busy, if_b.done, if_b.pass, if_b.signature, if_b.pat_cnt};
      default: o = '{if_c.busy, if_c.done, if_c.pass, if_c.signature, if_c.pat_cnt};
    endcase
    return o;
  endfunction

  task automatic set_in(int k, logic st, logic v, logic [SIG_W-1:0] d, logic [SIG_W-1:0] g);
    case (k)
      0:       begin if_a.start = st; if_a.data_valid = v; if_a.data_in = d; if_a.golden = g; end
      1:       begin if_b.start = st; if_b.data_valid = v; if_b.data_in = d; if_b.golden = g; end
      default: begin if_c.start = st; if_c.data_valid = v; if_c.data_in = d; if_c.golden = g; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) set_in(k, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    o = get_obs(2);
    total++; if (o.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o.busy); end
    total++; if (o.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o.done); end
    total++; if (o.pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", o.pass); end
    total++; if (o.sig !== '0) begin bad++; $display("FAIL reset_sig got=%h want=0", o.sig); end
    total++; if (o.cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", o.cnt); end
    o = get_obs(0);
    total++; if (o.done !== 1'b0) begin bad++; $display("FAIL reset_done_p1 got=%b want=0", o.done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_pattern();
    obs_t o;
    exp_t e;
    logic [SIG_W-1:0] s;
    set_in(0, 1'b1, 1'b0, '0, '0);
    tick();
    s = m_step(seed_exp(), 17'h00001);
    set_in(0, 1'b0, 1'b1, 17'h00001, s);
    sb_q.push_back('{s, 16'd1, 1'b1});
    tick();
    set_in(0, 1'b0, 1'b0, '0, '0);
    o = get_obs(0);
    e = sb_q.pop_front();
    total++; if (o.done !== 1'b1) begin bad++; $display("FAIL single_done got=%b want=1", o.done); end
    total++; if (o.busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", o.busy); end
    total++; if (o.sig !== e.sig) begin bad++; $display("FAIL single_sig got=%h want=%h", o.sig, e.sig); end
    total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL single_cnt got=%0d want=%0d", o.cnt, e.cnt); end
    total++; if (o.pass !== e.pass) begin bad++; $display("FAIL single_pass got=%b want=%b", o.pass, e.pass); end
  endtask

  task automatic test_feedback();
    obs_t o;
    exp_t e;
    set_in(1, 1'b1, 1'b0, '0, '0);
    tick();
    set_in(1, 1'b0, 1'b1, 17'h10000, '0);
    tick();
    o = get_obs(1);
    total++; if (o.sig !== 17'h10000) begin bad++; $display("FAIL fb_first_sig got=%h want=10000", o.sig); end
    total++; if (o.done !== 1'b0) begin bad++; $display("FAIL fb_early_done got=%b want=0", o.done); end
    total++; if (o.busy !== 1'b1) begin bad++; $display("FAIL fb_busy got=%b want=1", o.busy); end
    set_in(1, 1'b0, 1'b1, 17'h00000, 17'h04001);
    sb_q.push_back('{17'h04001, 16'd2, 1'b1});
    tick();
    set_in(1, 1'b0, 1'b0, '0, '0);
    o = get_obs(1);
    e = sb_q.pop_front();
    total++; if (o.done !== 1'b1) begin bad++; $display("FAIL fb_done got=%b want=1", o.done); end
    total++; if (o.sig !== e.sig) begin bad++; $display("FAIL fb_sig got=%h want=%h", o.sig, e.sig); end
    total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL fb_cnt got=%0d want=%0d", o.cnt, e.cnt); end
    total++; if (o.pass !== e.pass) begin bad++; $display("FAIL fb_pass got=%b want=%b", o.pass, e.pass); end
  endtask

  task automatic test_done_restart();
    obs_t o;
    exp_t e;
    logic [SIG_W-1:0] s;
    set_in(1, 1'b1, 1'b1, 17'h00001, '0);
    tick();
    set_in(1, 1'b0, 1'b0, '0, '0);
    o = get_obs(1);
    total++; if (o.busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", o.busy); end
    total++; if (o.cnt !== 16'd0) begin bad++; $display("FAIL restart_cnt got=%0d want=0", o.cnt); end
    total++; if (o.sig !== seed_exp()) begin bad++; $display("FAIL restart_sig got=%h want=%h", o.sig, seed_exp()); end
    total++; if (o.pass !== 1'b0) begin bad++; $display("FAIL restart_pass got=%b want=0", o.pass); end
    s = m_step(m_step(seed_exp(), 17'h00003), 17'h00005);
    set_in(1, 1'b0, 1'b1, 17'h00003, '0);
    tick();
    set_in(1, 1'b0, 1'b1, 17'h00005, s ^ 17'h00100);
    sb_q.push_back('{s, 16'd2, 1'b0});
    tick();
    set_in(1, 1'b0, 1'b0, '0, '0);
    o = get_obs(1);
    e = sb_q.pop_front();
    total++; if (o.done !== 1'b1) begin bad++; $display("FAIL wrong_gold_done got=%b want=1", o.done); end
    total++; if (o.sig !== e.sig) begin bad++; $display("FAIL wrong_gold_sig got=%h want=%h", o.sig, e.sig); end
    total++; if (o.pass !== e.pass) begin bad++; $display("FAIL wrong_gold_pass got=%b want=%b", o.pass, e.pass); end
  endtask

  task automatic test_stall();
    obs_t o;
    exp_t e;
    set_in(1, 1'b1, 1'b0, '0, '0);
    tick();
    set_in(1, 1'b0, 1'b1, 17'h00001, '0);
    tick();
    set_in(1, 1'b0, 1'b0, 17'h1FFFF, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      o = get_obs(1);
      total++; if (o.busy !== 1'b1) begin bad++; $display("FAIL stall_busy[%0d] got=%b want=1", i, o.busy); end
      total++; if (o.sig !== 17'h00001 || o.cnt !== 16'd1)
        begin bad++; $display("FAIL stall_hold[%0d] got=%h/%0d want=00001/1", i, o.sig, o.cnt); end
    end
    set_in(1, 1'b0, 1'b1, 17'h00000, 17'h00002);
    sb_q.push_back('{17'h00002, 16'd2, 1'b1});
    tick();
    set_in(1, 1'b0, 1'b0, '0, '0);
    o = get_obs(1);
    e = sb_q.pop_front();
    total++; if (o.done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b want=1", o.done); end
    total++; if (o.sig !== e.sig) begin bad++; $display("FAIL stall_sig got=%h want=%h", o.sig, e.sig); end
    total++; if (o.pass !== e.pass) begin bad++; $display("FAIL stall_pass got=%b want=%b", o.pass, e.pass); end
  endtask

  task automatic test_midrun_reset();
    obs_t o;
    exp_t e;
    logic [SIG_W-1:0] w[256];
    logic [SIG_W-1:0] s;
    logic seen;
    for (int i = 0; i < 256; i++) w[i] = SIG_W'($urandom);
    set_in(2, 1'b1, 1'b0, '0, '0);
    tick();
    for (int i = 0; i < 100; i++) begin
      set_in(2, (i == 50), 1'b1, w[i], '0);
      tick();
    end
    set_in(2, 1'b0, 1'b1, w[100], '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(2, 1'b0, 1'b0, '0, '0);
    o = get_obs(2);
    total++; if (o.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", o.busy); end
    total++; if (o.done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b want=0", o.done); end
    total++; if (o.pass !== 1'b0) begin bad++; $display("FAIL mid_rst_pass got=%b want=0", o.pass); end
    total++; if (o.sig !== '0) begin bad++; $display("FAIL mid_rst_sig got=%h want=0", o.sig); end
    total++; if (o.cnt !== '0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", o.cnt); end
    s = seed_exp();
    for (int i = 0; i < 256; i++) s = m_step(s, w[i]);
    sb_q.push_back('{s, 16'd256, 1'b1});
    set_in(2, 1'b1, 1'b0, '0, '0);
    tick();
    for (int i = 0; i < 256; i++) begin
      set_in(2, (i == 17), 1'b1, w[i], s);
      tick();
      if (i == 254) begin
        o = get_obs(2);
        total++; if (o.done !== 1'b0 || o.cnt !== 16'd255)
          begin bad++; $display("FAIL full_pre_last got=done %b cnt %0d want=done 0 cnt 255", o.done, o.cnt); end
      end
    end
    set_in(2, 1'b0, 1'b0, '0, '0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      o = get_obs(2);
      if (o.done === 1'b1) seen = 1'b1;
      else tick();
    end
    e = sb_q.pop_front();
    total++; if (!seen) begin bad++; $display("FAIL full_done_timeout got=done %b want=1", o.done); end
    total++; if (o.sig !== e.sig) begin bad++; $display("FAIL full_sig got=%h want=%h", o.sig, e.sig); end
    total++; if (o.cnt !== e.cnt) begin bad++; $display("FAIL full_cnt got=%0d want=%0d", o.cnt, e.cnt); end
    total++; if (o.pass !== e.pass) begin bad++; $display("FAIL full_pass got=%b want=%b", o.pass, e.pass); end
  endtask

`ifdef MISR_SEED_EN
  task automatic test_seed();
    obs_t o;
    exp_t e;
    logic [SIG_W-1:0] s;
    seed_val = 17'h1ABCD;
    set_in(0, 1'b1, 1'b0, '0, '0);
    tick();
    o = get_obs(0);
    total++; if (o.sig !== 17'h1ABCD) begin bad++; $display("FAIL seed_load got=%h want=1abcd", o.sig); end
    s = m_step(17'h1ABCD, 17'h00000);
    set_in(0, 1'b0, 1'b1, 17'h00000, s ^ 17'h00001);
    sb_q.push_back('{s, 16'd1, 1'b0});
    tick();
    set_in(0, 1'b0, 1'b0, '0, '0);
    o = get_obs(0);
    e = sb_q.pop_front();
    total++; if (o.done !== 1'b1) begin bad++; $display("FAIL seed_done got=%b want=1", o.done); end
    total++; if (o.sig !== e.sig) begin bad++; $display("FAIL seed_sig got=%h want=%h", o.sig, e.sig); end
    total++; if (o.pass !== e.pass) begin bad++; $display("FAIL seed_pass got=%b want=%b", o.pass, e.pass); end
  endtask
`endif

  initial begin
`ifdef MISR_SEED_EN
    seed_val = '0;
`endif
    test_reset();
    test_single_pattern();
    test_feedback();
    test_done_restart();
    test_stall();
    test_midrun_reset();
`ifdef MISR_SEED_EN
    test_seed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
